// File: rtl/reservation_station.sv
// Reservation station for the ALU functional unit.
// Buffers issued ops, captures operands from the ALU and LSB result
// broadcasts, and dispatches the lowest-index ready entry on a registered bus.
// Optional: define RS_BYPASS_EN to let a fully-ready issue skip the buffer
// when no stored entry is ready to dispatch.

`ifndef OP_LOG
`define OP_LOG 6
`endif
`ifndef ROB_LOG
`define ROB_LOG 4
`endif
`ifndef OP_NOP
`define OP_NOP 0
`endif

module reservation_station #(
   parameter int RS_LOG  = 4,
   parameter int OP_LOG  = `OP_LOG,
   parameter int ROB_LOG = `ROB_LOG
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rdy,
   input  logic               clear,
   input  logic               ID_valid,
   input  logic [OP_LOG-1:0]  ID_op,
   input  logic               ID_Qj_busy,
   input  logic [ROB_LOG-1:0] ID_Qj,
   input  logic [31:0]        ID_Vj,
   input  logic               ID_Qk_busy,
   input  logic [ROB_LOG-1:0] ID_Qk,
   input  logic [31:0]        ID_Vk,
   input  logic [31:0]        ID_Imm,
   input  logic [ROB_LOG-1:0] ID_DestRob,
   input  logic [31:0]        ID_CurPC,
   input  logic               B_enable,
   input  logic [ROB_LOG-1:0] B_RobId,
   input  logic [31:0]        B_value,
   input  logic               LSB_enable,
   input  logic [ROB_LOG-1:0] LSB_RobId,
   input  logic [31:0]        LSB_value,
   output logic               RS_full,
   output logic               RS_valid,
   output logic [OP_LOG-1:0]  RS_op,
   output logic [31:0]        RS_Vj,
   output logic [31:0]        RS_Vk,
   output logic [31:0]        RS_Imm,
   output logic [ROB_LOG-1:0] RS_DestRob,
   output logic [31:0]        RS_CurPC
);

   localparam int                RS_SIZE   = 2 ** RS_LOG;
   localparam logic [OP_LOG-1:0] OP_NOP    = OP_LOG'(`OP_NOP);
   localparam logic [RS_LOG:0]   FULL_MARK = (RS_LOG + 1)'(RS_SIZE - 1);
   localparam logic [RS_LOG:0]   CNT_ONE   = (RS_LOG + 1)'(1);

   logic [RS_SIZE-1:0] ent_valid;
   logic [RS_SIZE-1:0] ent_qj_busy;
   logic [RS_SIZE-1:0] ent_qk_busy;
   logic [ROB_LOG-1:0] ent_qj   [RS_SIZE];
   logic [ROB_LOG-1:0] ent_qk   [RS_SIZE];
   logic [31:0]        ent_vj   [RS_SIZE];
   logic [31:0]        ent_vk   [RS_SIZE];
   logic [OP_LOG-1:0]  ent_op   [RS_SIZE];
   logic [31:0]        ent_imm  [RS_SIZE];
   logic [ROB_LOG-1:0] ent_dest [RS_SIZE];
   logic [31:0]        ent_pc   [RS_SIZE];

   logic [RS_LOG:0]    count;
   logic [RS_LOG:0]    count_next;

   logic               has_free;
   logic [RS_LOG-1:0]  free_idx;
   logic               has_sel;
   logic [RS_LOG-1:0]  sel_idx;

   logic               iss_qj_busy;
   logic [31:0]        iss_vj;
   logic               iss_qk_busy;
   logic [31:0]        iss_vk;
   logic               do_bypass;
   logic               do_store;

   // Lowest free slot for issue and lowest ready slot for dispatch.
   always_comb begin
      has_free = 1'b0;
      free_idx = '0;
      has_sel  = 1'b0;
      sel_idx  = '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
         if (!has_free && !ent_valid[RS_LOG'(i)]) begin
            has_free = 1'b1;
            free_idx = RS_LOG'(i);
         end
         if (!has_sel && ent_valid[RS_LOG'(i)] &&
             !ent_qj_busy[RS_LOG'(i)] && !ent_qk_busy[RS_LOG'(i)]) begin
            has_sel = 1'b1;
            sel_idx = RS_LOG'(i);
         end
      end
   end

   // Same-cycle forwarding of broadcast results into the issuing op.
   always_comb begin
      iss_qj_busy = ID_Qj_busy;
      iss_vj      = ID_Vj;
      iss_qk_busy = ID_Qk_busy;
      iss_vk      = ID_Vk;
      if (ID_Qj_busy && B_enable && B_RobId == ID_Qj) begin
         iss_qj_busy = 1'b0;
         iss_vj      = B_value;
      end else if (ID_Qj_busy && LSB_enable && LSB_RobId == ID_Qj) begin
         iss_qj_busy = 1'b0;
         iss_vj      = LSB_value;
      end
      if (ID_Qk_busy && B_enable && B_RobId == ID_Qk) begin
         iss_qk_busy = 1'b0;
         iss_vk      = B_value;
      end else if (ID_Qk_busy && LSB_enable && LSB_RobId == ID_Qk) begin
         iss_qk_busy = 1'b0;
         iss_vk      = LSB_value;
      end
   end

   // Decide whether the issuing op bypasses the buffer or is stored.
   always_comb begin
`ifdef RS_BYPASS_EN
      do_bypass = ID_valid && !iss_qj_busy && !iss_qk_busy && !has_sel;
`else
      do_bypass = 1'b0;
`endif
      do_store = ID_valid && has_free && !do_bypass;
   end

   // Occupancy after the coming edge, used for the registered full flag.
   always_comb begin
      count_next = count;
      if (has_sel)
         count_next = count_next - CNT_ONE;
      if (do_store)
         count_next = count_next + CNT_ONE;
   end

   // Entry state, wakeup, issue, dispatch and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent_valid   <= '0;
         ent_qj_busy <= '0;
         ent_qk_busy <= '0;
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            ent_qj[RS_LOG'(i)]   <= '0;
            ent_qk[RS_LOG'(i)]   <= '0;
            ent_vj[RS_LOG'(i)]   <= '0;
            ent_vk[RS_LOG'(i)]   <= '0;
            ent_op[RS_LOG'(i)]   <= OP_NOP;
            ent_imm[RS_LOG'(i)]  <= '0;
            ent_dest[RS_LOG'(i)] <= '0;
            ent_pc[RS_LOG'(i)]   <= '0;
         end
         count      <= '0;
         RS_full    <= 1'b0;
         RS_valid   <= 1'b0;
         RS_op      <= OP_NOP;
         RS_Vj      <= '0;
         RS_Vk      <= '0;
         RS_Imm     <= '0;
         RS_DestRob <= '0;
         RS_CurPC   <= '0;
      end else if (clear) begin
         ent_valid <= '0;
         count     <= '0;
         RS_full   <= 1'b0;
         RS_valid  <= 1'b0;
         RS_op     <= OP_NOP;
      end else if (rdy) begin
         for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (ent_valid[RS_LOG'(i)] && ent_qj_busy[RS_LOG'(i)]) begin
               if (B_enable && B_RobId == ent_qj[RS_LOG'(i)]) begin
                  ent_qj_busy[RS_LOG'(i)] <= 1'b0;
                  ent_vj[RS_LOG'(i)]      <= B_value;
               end else if (LSB_enable && LSB_RobId == ent_qj[RS_LOG'(i)]) begin
                  ent_qj_busy[RS_LOG'(i)] <= 1'b0;
                  ent_vj[RS_LOG'(i)]      <= LSB_value;
               end
            end
            if (ent_valid[RS_LOG'(i)] && ent_qk_busy[RS_LOG'(i)]) begin
               if (B_enable && B_RobId == ent_qk[RS_LOG'(i)]) begin
                  ent_qk_busy[RS_LOG'(i)] <= 1'b0;
                  ent_vk[RS_LOG'(i)]      <= B_value;
               end else if (LSB_enable && LSB_RobId == ent_qk[RS_LOG'(i)]) begin
                  ent_qk_busy[RS_LOG'(i)] <= 1'b0;
                  ent_vk[RS_LOG'(i)]      <= LSB_value;
               end
            end
         end

         // The free slot is never the selected slot, so both writes coexist.
         if (do_store) begin
            ent_valid[free_idx]   <= 1'b1;
            ent_qj_busy[free_idx] <= iss_qj_busy;
            ent_qk_busy[free_idx] <= iss_qk_busy;
            ent_qj[free_idx]      <= ID_Qj;
            ent_qk[free_idx]      <= ID_Qk;
            ent_vj[free_idx]      <= iss_vj;
            ent_vk[free_idx]      <= iss_vk;
            ent_op[free_idx]      <= ID_op;
            ent_imm[free_idx]     <= ID_Imm;
            ent_dest[free_idx]    <= ID_DestRob;
            ent_pc[free_idx]      <= ID_CurPC;
         end

         if (has_sel) begin
            ent_valid[sel_idx] <= 1'b0;
            RS_valid   <= 1'b1;
            RS_op      <= ent_op[sel_idx];
            RS_Vj      <= ent_vj[sel_idx];
            RS_Vk      <= ent_vk[sel_idx];
            RS_Imm     <= ent_imm[sel_idx];
            RS_DestRob <= ent_dest[sel_idx];
            RS_CurPC   <= ent_pc[sel_idx];
         end else if (do_bypass) begin
            RS_valid   <= 1'b1;
            RS_op      <= ID_op;
            RS_Vj      <= iss_vj;
            RS_Vk      <= iss_vk;
            RS_Imm     <= ID_Imm;
            RS_DestRob <= ID_DestRob;
            RS_CurPC   <= ID_CurPC;
         end else begin
            RS_valid <= 1'b0;
            RS_op    <= OP_NOP;
         end

         count   <= count_next;
         RS_full <= (count_next >= FULL_MARK);
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Testbench for reservation_station: directed scenarios plus randomized
// traffic, compared every cycle against a slot-list reference model.

`ifndef OP_LOG
`define OP_LOG 6
`endif
`ifndef ROB_LOG
`define ROB_LOG 4
`endif
`ifndef OP_NOP
`define OP_NOP 0
`endif

module tb_reservation_station;

   localparam int RS_LOG  = 4;
   localparam int RS_SIZE = 2 ** RS_LOG;
   localparam int OP_LOG  = `OP_LOG;
   localparam int ROB_LOG = `ROB_LOG;
   localparam logic [OP_LOG-1:0] OP_NOP  = OP_LOG'(`OP_NOP);
   localparam logic [OP_LOG-1:0] OP_ADD  = OP_LOG'(1);
   localparam logic [OP_LOG-1:0] OP_ADDI = OP_LOG'(11);

   logic               clk = 1'b0;
   logic               rst_n, rdy, clear;
   logic               ID_valid;
   logic [OP_LOG-1:0]  ID_op;
   logic               ID_Qj_busy, ID_Qk_busy;
   logic [ROB_LOG-1:0] ID_Qj, ID_Qk, ID_DestRob;
   logic [31:0]        ID_Vj, ID_Vk, ID_Imm, ID_CurPC;
   logic               B_enable, LSB_enable;
   logic [ROB_LOG-1:0] B_RobId, LSB_RobId;
   logic [31:0]        B_value, LSB_value;
   logic               RS_full, RS_valid;
   logic [OP_LOG-1:0]  RS_op;
   logic [31:0]        RS_Vj, RS_Vk, RS_Imm, RS_CurPC;
   logic [ROB_LOG-1:0] RS_DestRob;

   int n_checks = 0;
   int n_errors = 0;

   reservation_station #(.RS_LOG(RS_LOG), .OP_LOG(OP_LOG), .ROB_LOG(ROB_LOG)) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
      .ID_valid(ID_valid), .ID_op(ID_op),
      .ID_Qj_busy(ID_Qj_busy), .ID_Qj(ID_Qj), .ID_Vj(ID_Vj),
      .ID_Qk_busy(ID_Qk_busy), .ID_Qk(ID_Qk), .ID_Vk(ID_Vk),
      .ID_Imm(ID_Imm), .ID_DestRob(ID_DestRob), .ID_CurPC(ID_CurPC),
      .B_enable(B_enable), .B_RobId(B_RobId), .B_value(B_value),
      .LSB_enable(LSB_enable), .LSB_RobId(LSB_RobId), .LSB_value(LSB_value),
      .RS_full(RS_full), .RS_valid(RS_valid), .RS_op(RS_op),
      .RS_Vj(RS_Vj), .RS_Vk(RS_Vk), .RS_Imm(RS_Imm),
      .RS_DestRob(RS_DestRob), .RS_CurPC(RS_CurPC)
   );

   always #5 clk = ~clk;

   // Reference model: a list of waiting ops plus the last dispatched op.
   typedef struct {
      bit         used;
      bit         wait_j;
      int         tag_j;
      bit [31:0]  val_j;
      bit         wait_k;
      int         tag_k;
      bit [31:0]  val_k;
      bit [31:0]  op;
      bit [31:0]  imm;
      bit [31:0]  dest;
      bit [31:0]  pc;
   } op_t;

   op_t       slots[RS_SIZE];
   op_t       out_op;
   bit        out_valid;
   bit        out_full;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < RS_SIZE; i++) slots[i].used = 0;
      out_op    = '{default: 0};
      out_op.op = 32'(OP_NOP);
      out_valid = 0;
      out_full  = 0;
   endtask

   // Value a broadcast delivers to a waiting tag this cycle, if any.
   function automatic bit bcast(input int tag, output bit [31:0] val);
      if (B_enable && int'(B_RobId) == tag) begin val = B_value; return 1; end
      if (LSB_enable && int'(LSB_RobId) == tag) begin val = LSB_value; return 1; end
      val = 0;
      return 0;
   endfunction

   task automatic model_edge();
      int   pick, hole, occupied;
      op_t  inc;
      bit [31:0] v;
      bit   bypass;
      if (clear) begin
         for (int i = 0; i < RS_SIZE; i++) slots[i].used = 0;
         out_valid = 0;
         out_op.op = 32'(OP_NOP);
         out_full  = 0;
         return;
      end
      if (!rdy) return;
      pick = -1;
      hole = -1;
      for (int i = 0; i < RS_SIZE; i++) begin
         if (pick < 0 && slots[i].used && !slots[i].wait_j && !slots[i].wait_k) pick = i;
         if (hole < 0 && !slots[i].used) hole = i;
      end
      inc = '{used: 1, wait_j: ID_Qj_busy, tag_j: int'(ID_Qj), val_j: ID_Vj,
              wait_k: ID_Qk_busy, tag_k: int'(ID_Qk), val_k: ID_Vk,
              op: 32'(ID_op), imm: ID_Imm, dest: 32'(ID_DestRob), pc: ID_CurPC};
      if (inc.wait_j && bcast(inc.tag_j, v)) begin inc.wait_j = 0; inc.val_j = v; end
      if (inc.wait_k && bcast(inc.tag_k, v)) begin inc.wait_k = 0; inc.val_k = v; end
      for (int i = 0; i < RS_SIZE; i++) if (slots[i].used) begin
         if (slots[i].wait_j && bcast(slots[i].tag_j, v)) begin slots[i].wait_j = 0; slots[i].val_j = v; end
         if (slots[i].wait_k && bcast(slots[i].tag_k, v)) begin slots[i].wait_k = 0; slots[i].val_k = v; end
      end
      bypass = 0;
`ifdef RS_BYPASS_EN
      bypass = ID_valid && !inc.wait_j && !inc.wait_k && pick < 0;
`endif
      if (pick >= 0) begin
         out_op    = slots[pick];
         out_valid = 1;
         slots[pick].used = 0;
      end else if (bypass) begin
         out_op    = inc;
         out_valid = 1;
      end else begin
         out_valid = 0;
         out_op.op = 32'(OP_NOP);
      end
      if (ID_valid && !bypass && hole >= 0) slots[hole] = inc;
      occupied = 0;
      for (int i = 0; i < RS_SIZE; i++) if (slots[i].used) occupied++;
      out_full = occupied >= RS_SIZE - 1;
   endtask

   task automatic compare_all();
      check("valid", RS_valid, out_valid);
      check("full", RS_full, out_full);
      check("op", RS_op, out_op.op);
      check("vj", RS_Vj, out_op.val_j);
      check("vk", RS_Vk, out_op.val_k);
      check("imm", RS_Imm, out_op.imm);
      check("dest", RS_DestRob, out_op.dest);
      check("pc", RS_CurPC, out_op.pc);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic idle();
      rdy = 1; clear = 0; ID_valid = 0;
      B_enable = 0; LSB_enable = 0;
   endtask

   task automatic set_issue(input logic [OP_LOG-1:0] op,
                            input logic jb, input logic [ROB_LOG-1:0] qj, input logic [31:0] vj,
                            input logic kb, input logic [ROB_LOG-1:0] qk, input logic [31:0] vk,
                            input logic [31:0] imm, input logic [ROB_LOG-1:0] dest, input logic [31:0] pc);
      ID_valid = 1; ID_op = op;
      ID_Qj_busy = jb; ID_Qj = qj; ID_Vj = vj;
      ID_Qk_busy = kb; ID_Qk = qk; ID_Vk = vk;
      ID_Imm = imm; ID_DestRob = dest; ID_CurPC = pc;
   endtask

   initial begin
      rst_n = 0;
      idle();
      set_issue(OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ID_valid = 0;
      B_RobId = 0; B_value = 0; LSB_RobId = 0; LSB_value = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      check("reset_valid", RS_valid, 0);
      check("reset_op", RS_op, OP_NOP);
      rst_n = 1;

      // Ready ADDI: dispatch latency and single-cycle valid pulse.
      set_issue(OP_ADDI, 0, 0, 5, 0, 0, 0, 7, 1, 32'h100);
      tick();
      idle();
`ifdef RS_BYPASS_EN
      check("addi_valid", RS_valid, 1);
`else
      check("addi_early", RS_valid, 0);
      tick();
      check("addi_valid", RS_valid, 1);
`endif
      check("addi_op", RS_op, OP_ADDI);
      check("addi_vj", RS_Vj, 5);
      check("addi_imm", RS_Imm, 7);
      tick();
      check("addi_pulse", RS_valid, 0);

      // ADD waiting on tag 3, woken by the ALU broadcast.
      set_issue(OP_ADD, 1, 3, 0, 0, 0, 32'h22, 0, 2, 32'h104);
      tick();
      idle();
      tick();
      check("add_blocked", RS_valid, 0);
      B_enable = 1; B_RobId = 3; B_value = 32'h10;
      tick();
      idle();
      check("add_wake_edge", RS_valid, 0);
      tick();
      check("add_valid", RS_valid, 1);
      check("add_vj", RS_Vj, 32'h10);
      tick();

      // Issue forwarded from the LSB broadcast in the same cycle.
      set_issue(OP_ADD, 0, 0, 1, 1, 6, 0, 0, 3, 32'h108);
      LSB_enable = 1; LSB_RobId = 6; LSB_value = 32'hAB;
      tick();
      idle();
`ifndef RS_BYPASS_EN
      check("fwd_early", RS_valid, 0);
      tick();
`endif
      check("fwd_valid", RS_valid, 1);
      check("fwd_vk", RS_Vk, 32'hAB);
      tick();

      // Fill RS_SIZE-1 blocked entries, then free one.
      for (int i = 0; i < RS_SIZE - 1; i++) begin
         set_issue(OP_ADD, 1, (i == 0) ? 4'(9) : 4'(10), 0, 0, 0, 32'(i), 0, 4'(i), 32'(i));
         tick();
      end
      idle();
      check("full_set", RS_full, 1);
      B_enable = 1; B_RobId = 9; B_value = 32'h99;
      tick();
      idle();
      check("full_hold", RS_full, 1);
      tick();
      check("full_disp", RS_valid, 1);
      check("full_drop", RS_full, 0);
      B_enable = 1; B_RobId = 10; B_value = 32'h77;
      tick();
      idle();
      repeat (RS_SIZE) tick();

      // Flush with a simultaneous issue.
      for (int i = 0; i < 5; i++) begin
         set_issue(OP_ADD, 1, 12, 0, 0, 0, 0, 0, 4'(i), 32'(i));
         tick();
      end
      set_issue(OP_ADDI, 0, 0, 1, 0, 0, 0, 1, 5, 32'h200);
      clear = 1;
      tick();
      idle();
      check("clr_valid", RS_valid, 0);
      check("clr_full", RS_full, 0);
      B_enable = 1; B_RobId = 12; B_value = 32'h5;
      tick();
      idle();
      repeat (3) tick();
      check("clr_nodisp", RS_valid, 0);

      // Stall with a matching broadcast present.
      set_issue(OP_ADD, 1, 13, 0, 0, 0, 0, 0, 6, 32'h300);
      tick();
      set_issue(OP_ADDI, 0, 0, 9, 0, 0, 0, 2, 7, 32'h304);
      tick();
      idle();
      rdy = 0;
      B_enable = 1; B_RobId = 13; B_value = 32'h55;
      repeat (3) tick();
      idle();
      repeat (3) tick();
      check("stall_nowake", RS_valid, 0);
      B_enable = 1; B_RobId = 13; B_value = 32'h66;
      tick();
      idle();
      tick();
      check("stall_resume", RS_valid, 1);
      check("stall_vj", RS_Vj, 32'h66);
      tick();

      // Randomized traffic.
      for (int c = 0; c < 800; c++) begin
         rdy   = ($urandom_range(0, 9) != 0);
         clear = ($urandom_range(0, 59) == 0);
         ID_valid   = !out_full && ($urandom_range(0, 2) != 0);
         ID_op      = OP_LOG'($urandom);
         ID_Qj_busy = $urandom_range(0, 1);
         ID_Qj      = ROB_LOG'($urandom_range(0, 7));
         ID_Vj      = $urandom;
         ID_Qk_busy = $urandom_range(0, 1);
         ID_Qk      = ROB_LOG'($urandom_range(0, 7));
         ID_Vk      = $urandom;
         ID_Imm     = $urandom;
         ID_DestRob = ROB_LOG'($urandom);
         ID_CurPC   = $urandom;
         B_enable   = $urandom_range(0, 1);
         B_RobId    = ROB_LOG'($urandom_range(0, 7));
         B_value    = $urandom;
         LSB_enable = $urandom_range(0, 1);
         LSB_RobId  = ROB_LOG'($urandom_range(0, 7));
         LSB_value  = $urandom;
         if (B_enable && LSB_enable && B_RobId == LSB_RobId) LSB_enable = 0;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
